// File: rtl/alu_mdu.sv
// Single-issue ALU with an iterative multiply/divide unit.
// Simple ops finish at the accept edge; MUL/MULHU/DIVU/REMU iterate one bit per cycle.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [3:0]       i_alu_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_alu_data,
  output logic             o_busy
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLT   = 4'd2;
  localparam logic [3:0] OP_SLTU  = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q, res_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             iter_op;

  assign shamt   = i_op_b[SHW-1:0];
  assign iter_op = (i_alu_op >= OP_MUL) && (i_alu_op <= OP_REMU);

  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      OP_ADD:  alu_res = i_op_a + i_op_b;
      OP_SUB:  alu_res = i_op_a - i_op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(i_op_a) < $signed(i_op_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, i_op_a < i_op_b};
      OP_XOR:  alu_res = i_op_a ^ i_op_b;
      OP_OR:   alu_res = i_op_a | i_op_b;
      OP_AND:  alu_res = i_op_a & i_op_b;
      OP_SLL:  alu_res = i_op_a << shamt;
      OP_SRL:  alu_res = i_op_a >> shamt;
      OP_SRA:  alu_res = $signed(i_op_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // hi/lo hold {product hi, multiplier/product lo} for multiply,
  // {partial remainder, dividend/quotient} for divide.
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d, div_hi_d, div_lo_d, div_diff;
  logic [WIDTH-1:0] iter_hi, iter_lo, fin_res;
  logic             div_ge, is_div;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};
    mul_hi_d = mul_sum[WIDTH:1];
    mul_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh[WIDTH-1:0] - b_q;
    div_hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
    div_lo_d = {lo_q[WIDTH-2:0], div_ge};
    is_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);
    iter_hi  = is_div ? div_hi_d : mul_hi_d;
    iter_lo  = is_div ? div_lo_d : mul_lo_d;
    case (op_q)
      OP_MUL:   fin_res = mul_lo_d;
      OP_MULHU: fin_res = mul_hi_d;
      OP_DIVU:  fin_res = div_lo_d;
      OP_REMU:  fin_res = div_hi_d;
      default:  fin_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          if (iter_op) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            op_q    <= i_alu_op;
            hi_q    <= '0;
            lo_q    <= i_op_a;
            b_q     <= i_op_b;
          end else begin
            state_q <= DONE;
            res_q   <= alu_res;
          end
        end
        BUSY: begin
          hi_q  <= iter_hi;
          lo_q  <= iter_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH-1)) begin
            state_q <= DONE;
            res_q   <= fin_res;
          end
        end
        DONE: if (i_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_busy     = (state_q == BUSY);
  assign o_valid    = (state_q == DONE);
  assign o_alu_data = res_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32): directed table, random ops vs model, corner sequences.
module tb_alu_mdu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_valid = 1'b0, i_ready = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [3:0]  alu_op = '0;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_data;
  int total = 0, bad = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(op_a), .i_op_b(op_b), .i_alu_op(alu_op), .o_valid(o_valid),
    .i_ready(i_ready), .o_alu_data(o_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    int sh;
    sh = int'(b % 32);
    p  = longint'(a) * longint'(b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a ^ b;
      5:  return a | b;
      6:  return a & b;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return 32'(int'(a) >>> sh);
      10: return p[31:0];
      11: return p[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one op, scramble inputs while it runs, return result, latency and busy-cycle count.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bsy);
    int w = 0;
    while (!o_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!o_ready) chk("ready_wait", 32'(o_ready), 32'd1);
    i_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    lat = 1; bsy = 0;
    while (!o_valid && lat < 100) begin
      if (o_busy) bsy++;
      op_a = $urandom; op_b = $urandom; alu_op = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    if (!o_valid) chk("valid_timeout", 32'(o_valid), 32'd1);
    res = o_data;
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("ready_after_hs", 32'(o_ready), 32'd1);
    chk("valid_after_hs", 32'(o_valid), 32'd0);
  endtask

  vec_t tbl[16];

  initial begin
    logic [31:0] res, held, ea, eb;
    logic [3:0]  rop;
    int lat, bsy, w;

    tbl[0]  = '{4'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000};
    tbl[1]  = '{4'd2,  32'h7FFF_FFFF, 32'd1,         32'd0};
    tbl[2]  = '{4'd3,  32'h7FFF_FFFF, 32'd1,         32'd0};
    tbl[3]  = '{4'd9,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
    tbl[4]  = '{4'd8,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000};
    tbl[5]  = '{4'd10, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
    tbl[6]  = '{4'd11, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001};
    tbl[7]  = '{4'd12, 32'd100,       32'd7,         32'd14};
    tbl[8]  = '{4'd13, 32'd100,       32'd7,         32'd2};
    tbl[9]  = '{4'd12, 32'd100,       32'd0,         32'hFFFF_FFFF};
    tbl[10] = '{4'd13, 32'd100,       32'd0,         32'd100};
    tbl[11] = '{4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF};
    tbl[12] = '{4'd7,  32'd1,         32'h0000_0021, 32'd2};
    tbl[13] = '{4'd2,  32'hFFFF_FFFF, 32'd1,         32'd1};
    tbl[14] = '{4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0};
    tbl[15] = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};

    // Reset state
    #12;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_data",  o_data,       32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, bsy);
      chk($sformatf("vec%0d_data", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), 32'(lat), (tbl[i].op inside {[10:13]}) ? 32'd33 : 32'd1);
      chk($sformatf("vec%0d_busy", i), 32'(bsy), (tbl[i].op inside {[10:13]}) ? 32'd32 : 32'd0);
    end

    // Random ops against the model
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ea  = $urandom;
      eb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 7) == 0) eb = '0;
      run_op(rop, ea, eb, res, lat, bsy);
      chk($sformatf("rnd%0d_op%0d_data", n, rop), res, model(rop, ea, eb));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), (rop inside {[10:13]}) ? 32'd33 : 32'd1);
    end

    // Backpressure: DONE held with i_ready low, competing request ignored
    i_valid = 1'b1; alu_op = 4'd0; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    alu_op = 4'd1; op_a = 32'd99; op_b = 32'd1;
    held = o_data;
    chk("bp_first", held, 32'd11);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), 32'(o_valid), 32'd1);
      chk($sformatf("bp%0d_data", c),  o_data,        held);
      chk($sformatf("bp%0d_ready", c), 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    chk("bp_release_valid", 32'(o_valid), 32'd0);

    // Reset in BUSY cycle 10 of a DIVU
    i_valid = 1'b1; alu_op = 4'd12; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    i_valid = 1'b0;
    w = 1;
    while (w < 10) begin @(posedge clk); #1; w++; end
    chk("mid_busy_before", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_busy",  32'(o_busy),  32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_data",  o_data,       32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(4'd0, 32'd3, 32'd4, res, lat, bsy);
    chk("post_rst_add", res, 32'd7);
    chk("post_rst_lat", 32'(lat), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two and at least 8.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  request valid; qualifies i_op_a, i_op_b and i_alu_op.
REQ-005 o_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 i_op_a  input  WIDTH  operand A; dividend for divide operations.
REQ-007 i_op_b  input  WIDTH  operand B; shift amount source; divisor for divide operations.
REQ-008 i_alu_op  input  4  operation select, encoded per REQ-013.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  consumer accepts the result.
REQ-011 o_alu_data  output  WIDTH  registered result.
REQ-012 o_busy  output  1  high while in BUSY.

Function
REQ-013 Op encoding: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU, 14-15 reserved.
REQ-014 Request acceptance: a request SHALL be accepted when i_valid and o_ready are both high at a clock edge; operands and op SHALL be latched at that edge.
REQ-015 i_valid with o_ready low SHALL be ignored, with no state change.
REQ-016 Arithmetic width: ADD and SUB SHALL wrap modulo 2^WIDTH.
REQ-017 SLT and SLTU: SLT SHALL compare as two's complement; SLTU SHALL compare unsigned; both SHALL return 1 zero-extended or 0.
REQ-018 Shift amount: SLL, SRL and SRA SHALL use only the low log2(WIDTH) bits of operand B; SRA SHALL sign-fill.
REQ-019 MUL and MULHU SHALL compute the unsigned 2*WIDTH-bit product of A and B with an iterative shift-add, one bit per cycle.
REQ-020 DIVU and REMU SHALL use an unsigned restoring divide, one quotient bit per cycle.
REQ-021 Divide by zero: a zero divisor SHALL give DIVU = all ones and REMU = dividend, with the normal latency.
REQ-022 Reserved ops 14-15 SHALL complete as single-cycle ops with result 0.
REQ-023 FSM states SHALL be IDLE, BUSY and DONE.
REQ-024 IDLE transitions on accept: ops 0-9 and 14-15 SHALL go to DONE, with the result registered at the accept edge; ops 10-13 SHALL go to BUSY, with the iteration counter cleared.
REQ-025 BUSY SHALL iterate exactly WIDTH cycles, then go to DONE with the selected result (low/high product, quotient or remainder) registered.
REQ-026 Latency from the accept edge to o_valid high: exactly 1 cycle for ops 0-9 and 14-15; exactly WIDTH+1 cycles for ops 10-13.
REQ-027 o_valid SHALL be high exactly when in DONE; o_busy SHALL be high exactly when in BUSY; o_ready SHALL be high exactly when in IDLE.
REQ-028 DONE with i_ready high SHALL go to IDLE at that edge; a new request is accepted no earlier than the following cycle.
REQ-029 Backpressure: while in DONE with i_ready low, o_valid SHALL stay high and o_alu_data SHALL stay stable indefinitely.
REQ-030 Input changes: in BUSY and DONE, changes on i_op_a, i_op_b and i_alu_op SHALL NOT affect the result.

Reset
REQ-031 While i_rst_n is low: state = IDLE, o_valid = 0, o_busy = 0, o_ready = 1, o_alu_data = 0, counter and internal operand registers = 0.
REQ-032 Reset mid-operation: asserting i_rst_n in BUSY or DONE SHALL abort the operation immediately, without waiting for a clock edge, and discard the result.
REQ-033 The first request after reset deasserts SHALL be acceptable at the first clock edge with i_rst_n high.

Verification (WIDTH=32)
REQ-034 ADD: A=0x7FFFFFFF, B=1 -> o_alu_data=0x80000000, o_valid 1 cycle after accept; SLT on the same operands -> 0, SLTU -> 0.
REQ-035 SRA: A=0x80000000, B=0x00000024 -> 0xF8000000 (shamt 4); SRL on the same operands -> 0x08000000.
REQ-036 MUL: A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE with o_valid exactly 33 cycles after accept and o_busy high for 32 cycles; MULHU on the same operands -> 0x00000001.
REQ-037 Divide: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; each completes in 33 cycles.
REQ-038 Backpressure: hold i_ready low for 5 cycles in DONE -> o_valid held high, o_alu_data unchanged, o_ready 0, a concurrent i_valid ignored; raise i_ready -> IDLE next cycle.
REQ-039 Reset mid-divide: assert i_rst_n low during BUSY cycle 10 of a DIVU -> o_valid 0, o_busy 0, o_ready 1 immediately; after release, ADD 3+4 -> 7.
